// File: rtl/stream_perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : stream_perf_monitor
//  Purpose  : Passive per-channel valid/ready transfer and stall counter with
//             a start/stop/length-bounded measurement window, plus producer
//             (ch 0) to consumer (ch NUM_CH-1) in-flight occupancy tracking.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_perf_monitor #(
   parameter  int NUM_CH    = 2,
   parameter  int CNT_WIDTH = 32,
   parameter  int WIN_WIDTH = 32,
   localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   input  logic [NUM_CH-1:0]    valid,
   input  logic [NUM_CH-1:0]    ready,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 clear,
   input  logic [WIN_WIDTH-1:0] win_len,
   input  logic [SEL_W-1:0]     rd_sel,
   output logic [CNT_WIDTH-1:0] rd_xfer,
   output logic [CNT_WIDTH-1:0] rd_stall,
   output logic [WIN_WIDTH-1:0] cycle_cnt,
   output logic [CNT_WIDTH-1:0] inflight,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_CH-1:0]    sat,
   output logic                 underflow
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIN_WIDTH-1:0] WIN_MAX  = {WIN_WIDTH{1'b1}};
   localparam logic [WIN_WIDTH-1:0] WIN_ONE  = {{(WIN_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [SEL_W:0]       NUM_CH_X = NUM_CH[SEL_W:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state;
   logic [WIN_WIDTH-1:0] win_q;
   logic [CNT_WIDTH-1:0] xfer  [NUM_CH];
   logic [CNT_WIDTH-1:0] stall [NUM_CH];

   logic do_start;
   logic counting;
   logic last_cycle;
   logic prod;
   logic cons;

   // Decode this cycle's control action; clear beats start beats stop.
   always_comb begin
      do_start   = !clear && start && (state != S_RUN);
      counting   = !clear && (state == S_RUN) && !stop;
      last_cycle = counting && (win_q != '0) && (cycle_cnt == (win_q - WIN_ONE));
      prod       = valid[0] & ready[0];
      cons       = valid[NUM_CH-1] & ready[NUM_CH-1];
   end

   // Window state machine with registered busy/done.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         win_q <= '0;
      end else begin
         done <= 1'b0;
         if (clear) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                     win_q <= win_len;
                  end
               end
               S_RUN: begin
                  // A stop cycle is not counted; the window's last cycle is.
                  if (stop || last_cycle) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Saturating window counters, sticky flags and in-flight occupancy.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n || clear || do_start) begin
         for (int c = 0; c < NUM_CH; c++) begin
            xfer[c]  <= '0;
            stall[c] <= '0;
         end
         sat       <= '0;
         cycle_cnt <= '0;
         inflight  <= '0;
         underflow <= 1'b0;
      end else if (counting) begin
         if (cycle_cnt != WIN_MAX) begin
            cycle_cnt <= cycle_cnt + WIN_ONE;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (valid[c] && ready[c] && (xfer[c] != CNT_MAX)) begin
               xfer[c] <= xfer[c] + CNT_ONE;
               if (xfer[c] == (CNT_MAX - CNT_ONE)) begin
                  sat[c] <= 1'b1;
               end
            end
            if (valid[c] && !ready[c] && (stall[c] != CNT_MAX)) begin
               stall[c] <= stall[c] + CNT_ONE;
               if (stall[c] == (CNT_MAX - CNT_ONE)) begin
                  sat[c] <= 1'b1;
               end
            end
         end
         // Simultaneous producer and consumer transfers cancel out.
         if (prod && !cons) begin
            if (inflight != CNT_MAX) begin
               inflight <= inflight + CNT_ONE;
            end
         end else if (cons && !prod) begin
            if (inflight == '0) begin
               underflow <= 1'b1;
            end else begin
               inflight <= inflight - CNT_ONE;
            end
         end
      end
   end

   // Registered readout mux; selects beyond the last channel read zero.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         rd_xfer  <= '0;
         rd_stall <= '0;
      end else if ({1'b0, rd_sel} < NUM_CH_X) begin
         rd_xfer  <= xfer[rd_sel];
         rd_stall <= stall[rd_sel];
      end else begin
         rd_xfer  <= '0;
         rd_stall <= '0;
      end
   end

endmodule
`default_nettype wire
